// File: rtl/cpu7_ifu_imd_pipe.sv
// Registered multi-lane immediate generator with a 2-entry skid buffer between decode and issue.
// Optional CPU7_IMD_BR_TGT_EN adds a per-lane pc+br_offs adder whose result rides with the beat.
module cpu7_ifu_imd_pipe #(
  parameter int unsigned LANES = 1,
  parameter int unsigned DW    = 32,
  parameter int unsigned OPW   = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [LANES*32-1:0]  in_inst,
  input  logic [LANES*OPW-1:0] in_op,
  input  logic [LANES*DW-1:0]  in_pc,
  input  logic [LANES-1:0]     in_lane_vld,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [LANES-1:0]     out_lane_vld,
  output logic [LANES*32-1:0]  out_imm_shifted,
  output logic [LANES*DW-1:0]  out_c,
  output logic [LANES*DW-1:0]  out_br_offs,
  output logic [LANES*DW-1:0]  out_br_tgt
);

  // Decoded-op bit layout; IMM_SHIFT is a 5-bit code at [19:15].
  localparam int unsigned OpI5         = 0;
  localparam int unsigned OpI12        = 1;
  localparam int unsigned OpI14        = 2;
  localparam int unsigned OpI16        = 3;
  localparam int unsigned OpI20        = 4;
  localparam int unsigned OpDoubleWord = 5;
  localparam int unsigned OpUnsign     = 6;
  localparam int unsigned OpCountL     = 7;
  localparam int unsigned OpCountT     = 8;
  localparam int unsigned OpSa         = 9;
  localparam int unsigned OpAlign      = 10;
  localparam int unsigned OpExt        = 11;
  localparam int unsigned OpIns        = 12;
  localparam int unsigned OpRdRead     = 13;
  localparam int unsigned OpHighTarget = 14;
  localparam int unsigned OpShLo       = 15;

  function automatic logic [31:0] imm_raw(input logic [25:0] inst, input logic [OPW-1:0] op);
    logic [31:0] imm;
    if (op[OpI5])       imm = op[OpDoubleWord] ? 32'(inst[15:10]) : 32'(inst[14:10]);
    else if (op[OpI12]) imm = op[OpUnsign] ? 32'(inst[21:10]) : 32'($signed(inst[21:10]));
    else if (op[OpI14]) imm = 32'($signed(inst[23:10]));
    else if (op[OpI16]) imm = 32'($signed(inst[25:10]));
    else if (op[OpI20]) imm = 32'($signed(inst[24:5]));
    else                imm = '0;
    return imm;
  endfunction

  function automatic logic [31:0] imm_shift(input logic [31:0] imm, input logic [4:0] code);
    logic [31:0] res;
    case (code)
      5'd2:    res = imm << 2;
      5'd12:   res = imm << 12;
      5'd16:   res = imm << 16;
      5'd18:   res = imm << 18;
      default: res = imm;
    endcase
    return res;
  endfunction

  function automatic logic [DW-1:0] aux_c(input logic [25:0] inst, input logic [OPW-1:0] op,
                                          input logic [31:0] imm);
    logic [DW-1:0] c;
    c = '0;
    if (op[OpCountL] | op[OpCountT]) c[0] = ~op[OpUnsign];
    else if (op[OpSa] | op[OpAlign]) c = DW'(inst[17:15]);
    else if (op[OpExt] | op[OpIns])  c = DW'(inst[21:10]);
    else                             c = DW'($signed(imm));
    return c;
  endfunction

  function automatic logic [DW-1:0] br_offs(input logic [25:0] inst, input logic [OPW-1:0] op);
    logic [DW-1:0] b;
    if (op[OpRdRead])           b = DW'($signed({inst[25:10], 2'b00}));
    else if (op[OpHighTarget])  b = DW'($signed({inst[9:0], inst[25:10], 2'b00}));
    else                        b = DW'($signed({inst[4:0], inst[25:10], 2'b00}));
    return b;
  endfunction

  logic [LANES*32-1:0] dec_imm;
  logic [LANES*DW-1:0] dec_c;
  logic [LANES*DW-1:0] dec_br;
`ifdef CPU7_IMD_BR_TGT_EN
  logic [LANES*DW-1:0] dec_tgt;
`else
  logic unused_pc;
  assign unused_pc = ^in_pc;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [31:0] raw;
    logic        unused_opc;
    assign unused_opc = ^in_inst[g*32+26 +: 6];
    assign raw = imm_raw(in_inst[g*32 +: 26], in_op[g*OPW +: OPW]);
    assign dec_imm[g*32 +: 32] = imm_shift(raw, in_op[g*OPW+OpShLo +: 5]);
    assign dec_c[g*DW +: DW]   = aux_c(in_inst[g*32 +: 26], in_op[g*OPW +: OPW], raw);
    assign dec_br[g*DW +: DW]  = br_offs(in_inst[g*32 +: 26], in_op[g*OPW +: OPW]);
`ifdef CPU7_IMD_BR_TGT_EN
    assign dec_tgt[g*DW +: DW] = in_pc[g*DW +: DW] + dec_br[g*DW +: DW];
`endif
  end

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;
  state_e state_q, state_d;
  logic   in_rdy_q;
  logic   accept, pop, load_out_in, load_out_skid, load_skid;

  always_comb begin
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    accept        = in_vld & in_rdy_q;
    pop           = out_vld & out_rdy;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: if (accept) begin state_d = StOne; load_out_in = 1'b1; end
        StOne: begin
          if (accept && !pop) begin state_d = StFull; load_skid = 1'b1; end
          else if (accept && pop) load_out_in = 1'b1;
          else if (pop) state_d = StEmpty;
        end
        StFull:  if (pop) begin state_d = StOne; load_out_skid = 1'b1; end
        default: state_d = StEmpty;
      endcase
    end
  end

  // in_rdy is registered so out_rdy never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StEmpty;
      in_rdy_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_rdy_q <= (state_d != StFull);
    end
  end

  assign in_rdy  = in_rdy_q;
  assign out_vld = (state_q != StEmpty);

  logic [LANES-1:0]    out_lv_q,  skid_lv_q;
  logic [LANES*32-1:0] out_imm_q, skid_imm_q;
  logic [LANES*DW-1:0] out_c_q,   skid_c_q;
  logic [LANES*DW-1:0] out_br_q,  skid_br_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_lv_q   <= '0;
      out_imm_q  <= '0;
      out_c_q    <= '0;
      out_br_q   <= '0;
      skid_lv_q  <= '0;
      skid_imm_q <= '0;
      skid_c_q   <= '0;
      skid_br_q  <= '0;
    end else begin
      if (load_out_in) begin
        out_lv_q  <= in_lane_vld;
        out_imm_q <= dec_imm;
        out_c_q   <= dec_c;
        out_br_q  <= dec_br;
      end else if (load_out_skid) begin
        out_lv_q  <= skid_lv_q;
        out_imm_q <= skid_imm_q;
        out_c_q   <= skid_c_q;
        out_br_q  <= skid_br_q;
      end
      if (load_skid) begin
        skid_lv_q  <= in_lane_vld;
        skid_imm_q <= dec_imm;
        skid_c_q   <= dec_c;
        skid_br_q  <= dec_br;
      end
    end
  end

  assign out_lane_vld    = out_lv_q;
  assign out_imm_shifted = out_imm_q;
  assign out_c           = out_c_q;
  assign out_br_offs     = out_br_q;

`ifdef CPU7_IMD_BR_TGT_EN
  logic [LANES*DW-1:0] out_tgt_q, skid_tgt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_tgt_q  <= '0;
      skid_tgt_q <= '0;
    end else begin
      if (load_out_in)        out_tgt_q <= dec_tgt;
      else if (load_out_skid) out_tgt_q <= skid_tgt_q;
      if (load_skid)          skid_tgt_q <= dec_tgt;
    end
  end

  assign out_br_tgt = out_tgt_q;
`else
  assign out_br_tgt = '0;
`endif

endmodule
